uart_rx_frame_ctrl: RTL and testbench

Frame-level receive controller that sits directly behind the UART receiver. It consumes the receiver's byte-done strobe and data byte, and parses frames of the form SOF, LEN, LEN payload bytes, CHK. Payload is buffered in an internal register file. A validated frame is presented to the host through a valid/ack handshake with random-access reads. Framing, length, checksum, inter-byte-timeout and overrun errors are flagged as one-cycle pulses.

---
 rtl/uart_rx_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame parser behind a UART receiver. It accepts frames of the form
//   SOF, LEN, LEN payload bytes, CHK. The checksum is (LEN + payload) mod 256.
//   Payload goes into a local register file. Once a frame checks good it is
//   held there for the host until frame_ack. Error conditions raise one-cycle
//   pulses.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   s_tick       16x baud sample tick, drives the inter-byte timeout
//   rx_done_tick strobe: rx_data carries a new byte
//   rx_data      received byte
//   frame_valid  a checked frame is held in the buffer
//   frame_len    payload length of the held frame
//   frame_ack    host releases the held frame; only looked at in HOLD
//   rd_addr      buffer read address
//   rd_data      buf[rd_addr] (combinational), 8'h00 beyond MAX_LEN
//   err_len      pulse: LEN byte is 0 or above MAX_LEN
//   err_chk      pulse: checksum mismatch
//   err_timeout  pulse: inter-byte silence while a frame is in progress
//   err_ovr      pulse: byte dropped while a frame is held
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter logic [7:0]  SOF_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_len,
  output logic              err_chk,
  output logic              err_timeout,
  output logic              err_ovr
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TmoW-1:0]   TmoLast = TmoW'(TIMEOUT_TICKS - 1);
  localparam logic [TmoW-1:0]   TmoOne  = TmoW'(1);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  state_e          state_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt_q;
  logic [7:0]      sum_q;
  logic [TmoW-1:0] tmo_q;
  logic [7:0]      buf_q [MAX_LEN];

  logic            frame_valid_q;
  logic [ADDR_W:0] frame_len_q;
  logic            err_len_q;
  logic            err_chk_q;
  logic            err_timeout_q;
  logic            err_ovr_q;

  logic            len_bad;
  logic            in_frame;

  // LEN byte is unusable when zero or larger than the buffer.
  assign len_bad  = (rx_data == 8'h00) || (32'(rx_data) > MAX_LEN);
  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StHunt;
      len_q         <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovr_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovr_q     <= 1'b0;

      // Timeout counter only matters inside a frame. A byte in the same cycle
      // as the terminal tick takes priority and clears the count.
      if (in_frame) begin
        if (rx_done_tick) begin
          tmo_q <= '0;
        end else if (s_tick) begin
          if (tmo_q == TmoLast) begin
            tmo_q         <= '0;
            err_timeout_q <= 1'b1;
            state_q       <= StHunt;
          end else begin
            tmo_q <= tmo_q + TmoOne;
          end
        end
      end

      unique case (state_q)
        StHunt: begin
          if (rx_done_tick && (rx_data == SOF_BYTE)) begin
            state_q <= StLen;
            tmo_q   <= '0;
          end
        end

        StLen: begin
          if (rx_done_tick) begin
            if (len_bad) begin
              err_len_q <= 1'b1;
              state_q   <= StHunt;
            end else begin
              len_q   <= (ADDR_W + 1)'(rx_data);
              sum_q   <= rx_data;
              cnt_q   <= '0;
              state_q <= StPayload;
            end
          end
        end

        StPayload: begin
          if (rx_done_tick) begin
            buf_q[cnt_q[ADDR_W-1:0]] <= rx_data;
            sum_q                    <= sum_q + rx_data;
            cnt_q                    <= cnt_q + CntOne;
            if (cnt_q == (len_q - CntOne)) begin
              state_q <= StChk;
            end
          end
        end

        StChk: begin
          if (rx_done_tick) begin
            if (rx_data == sum_q) begin
              frame_valid_q <= 1'b1;
              frame_len_q   <= len_q;
              state_q       <= StHold;
            end else begin
              // Buffer keeps whatever payload was written; no rollback.
              err_chk_q <= 1'b1;
              state_q   <= StHunt;
            end
          end
        end

        StHold: begin
          // Anything arriving now is lost, including a SOF.
          if (rx_done_tick) begin
            err_ovr_q <= 1'b1;
          end
          if (frame_ack) begin
            frame_valid_q <= 1'b0;
            state_q       <= StHunt;
          end
        end

        default: begin
          state_q <= StHunt;
        end
      endcase
    end
  end

  generate
    if (MAX_LEN >= (2 ** ADDR_W)) begin : g_rd_full
      assign rd_data = buf_q[rd_addr];
    end else begin : g_rd_partial
      assign rd_data = (32'(rd_addr) < MAX_LEN) ? buf_q[rd_addr] : 8'h00;
    end
  endgenerate

  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign err_len     = err_len_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_timeout_q;
  assign err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with hand-computed expectations.
module tb_uart_rx_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic       frame_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic       err_ovr;

  int checks;
  int errors;

  uart_rx_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_len    (frame_len),
    .frame_ack    (frame_ack),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .err_len      (err_len),
    .err_chk      (err_chk),
    .err_timeout  (err_timeout),
    .err_ovr      (err_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic send_tick();
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data[%0d] got %h want %h", name, a, rd_data, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({frame_valid, frame_len, err_len, err_chk, err_timeout, err_ovr} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b len=%0d errs=%b%b%b%b want all 0", frame_valid,
               frame_len, err_len, err_chk, err_timeout, err_ovr);
    end
    check_rd("reset_buf0", 4'd0, 8'h00);
    check_rd("reset_buf15", 4'd15, 8'h00);
  endtask

  task automatic test_good_frame();
    logic [7:0] f [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_early_valid: got %b want 0", frame_valid);
    end
    send_byte(f[5]);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd3) begin
      errors++;
      $display("FAIL good_valid: got v=%b len=%0d want v=1 len=3", frame_valid, frame_len);
    end
    check_rd("good_rd0", 4'd0, 8'h11);
    check_rd("good_rd1", 4'd1, 8'h22);
    check_rd("good_rd2", 4'd2, 8'h33);
    ack();
    checks++;
    if (frame_valid !== 1'b0 || frame_len !== 5'd3) begin
      errors++;
      $display("FAIL good_ack: got v=%b len=%0d want v=0 len=3", frame_valid, frame_len);
    end
  endtask

  task automatic test_noise_bad_chk();
    logic [7:0] noise [3] = '{8'h00, 8'hFF, 8'h7E};
    logic [7:0] bad [6]   = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    logic [7:0] wrap [4]  = '{8'hA5, 8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      send_byte(noise[i]);
      checks++;
      if ({err_len, err_chk, err_timeout, err_ovr, frame_valid} !== 5'd0) begin
        errors++;
        $display("FAIL noise_%0d: got errs/valid %b want 00000", i,
                 {err_len, err_chk, err_timeout, err_ovr, frame_valid});
      end
    end
    for (int i = 0; i < 6; i++) send_byte(bad[i]);
    checks++;
    if (err_chk !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_pulse: got chk=%b v=%b want chk=1 v=0", err_chk, frame_valid);
    end
    step();
    checks++;
    if (err_chk !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_once: got chk=%b v=%b want chk=0 v=0", err_chk, frame_valid);
    end
    for (int i = 0; i < 4; i++) send_byte(wrap[i]);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd1 || err_chk !== 1'b0) begin
      errors++;
      $display("FAIL wrap_valid: got v=%b len=%0d chk=%b want v=1 len=1 chk=0", frame_valid,
               frame_len, err_chk);
    end
    check_rd("wrap_rd0", 4'd0, 8'hFF);
    check_rd("wrap_stale1", 4'd1, 8'h22);
    ack();
  endtask

  task automatic test_len_limits();
    send_byte(8'hA5);
    send_byte(8'h00);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_zero: got err_len=%b want 1", err_len);
    end
    send_byte(8'hA5);
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL len_pulse_width: got err_len=%b want 0", err_len);
    end
    send_byte(8'h11);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_17: got err_len=%b want 1", err_len);
    end
    send_byte(8'hA5);
    send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd16 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL len_max: got v=%b len=%0d err_len=%b want v=1 len=16 err_len=0",
               frame_valid, frame_len, err_len);
    end
    check_rd("len_max_rd0", 4'd0, 8'h01);
    check_rd("len_max_rd15", 4'd15, 8'h10);
    ack();
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    repeat (319) send_tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got err_timeout=%b want 0 after 319 ticks", err_timeout);
    end
    send_tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_320: got err_timeout=%b want 1", err_timeout);
    end
    step();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: got err_timeout=%b want 0", err_timeout);
    end
    // Same prefix, but the next byte lands on the 320th tick.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    repeat (319) send_tick();
    s_tick = 1'b1;
    send_byte(8'h22);
    s_tick = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_byte_wins: got err_timeout=%b want 0", err_timeout);
    end
    send_byte(8'h33);
    send_byte(8'h69);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd3 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_then_good: got v=%b len=%0d tmo=%b want v=1 len=3 tmo=0",
               frame_valid, frame_len, err_timeout);
    end
    check_rd("tmo_rd1", 4'd1, 8'h22);
    ack();
  endtask

  task automatic test_overrun();
    logic [7:0] f [5] = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
    for (int i = 0; i < 5; i++) send_byte(f[i]);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL ovr_hold: got v=%b len=%0d want v=1 len=2", frame_valid, frame_len);
    end
    send_byte(8'hA5);
    checks++;
    if (err_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_first: got err_ovr=%b want 1", err_ovr);
    end
    send_byte(8'h02);
    checks++;
    if (err_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: got err_ovr=%b want 1", err_ovr);
    end
    step();
    checks++;
    if (err_ovr !== 1'b0 || frame_valid !== 1'b1 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL ovr_after: got ovr=%b v=%b len=%0d want ovr=0 v=1 len=2", err_ovr,
               frame_valid, frame_len);
    end
    check_rd("ovr_rd0", 4'd0, 8'hAA);
    check_rd("ovr_rd1", 4'd1, 8'hBB);
    ack();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack: got v=%b want 0", frame_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    reset = 1'b0;
    #2;
    checks++;
    if ({frame_valid, frame_len, err_len, err_chk, err_timeout, err_ovr} !== 10'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b len=%0d errs=%b%b%b%b want all 0", frame_valid,
               frame_len, err_len, err_chk, err_timeout, err_ovr);
    end
    check_rd("midreset_buf0", 4'd0, 8'h00);
    check_rd("midreset_buf1", 4'd1, 8'h00);
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 6; i++) send_byte(f[i]);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 5'd3) begin
      errors++;
      $display("FAIL midreset_good: got v=%b len=%0d want v=1 len=3", frame_valid, frame_len);
    end
    check_rd("midreset_rd2", 4'd2, 8'h33);
    ack();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    s_tick       = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    frame_ack    = 1'b0;
    rd_addr      = 4'd0;
    repeat (3) step();
    test_reset();
    reset = 1'b1;
    step();
    test_good_frame();
    test_noise_bad_chk();
    test_len_limits();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
